// File: rtl/stopwatch_mode_ctrl_if.sv
// Front-panel signal bundle between the stopwatch buttons/datapath and stopwatch_mode_ctrl.
interface stopwatch_mode_ctrl_if;
  logic       btn_ss;
  logic       btn_lap;
  logic       count_en;
  logic       count_clr;
  logic       lap_hold;
  logic [1:0] state;

  modport master (
    output btn_ss, btn_lap,
    input  count_en, count_clr, lap_hold, state
  );

  modport slave (
    input  btn_ss, btn_lap,
    output count_en, count_clr, lap_hold, state
  );
endinterface

// File: rtl/stopwatch_mode_ctrl.sv
// Stopwatch front-panel controller: button sync/debounce/press detect, LAP short/long
// classification and IDLE/RUN/LAP/PAUSE sequencing. Optional macro: SS_LONG_CLEAR_EN.
module stopwatch_mode_ctrl #(
  parameter int DB_CYCLES   = 16,
  parameter int LONG_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stopwatch_mode_ctrl_if.slave pnl
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int HW  = $clog2(LONG_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  LONG_V  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0]  LONG_M1 = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_e;

  // bit 0 = START/STOP, bit 1 = LAP
  logic [1:0] btn_raw;
  logic [1:0] db;
  logic [1:0] db_dly_q;

  assign btn_raw = {pnl.btn_lap, pnl.btn_ss};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic           sync1_q;
    logic           sync2_q;
    logic           db_q;
    logic [DBW-1:0] cnt_q;

    // Level flips only after DB_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        db_q    <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw[g];
        sync2_q <= sync1_q;
        if (sync2_q == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          db_q  <= ~db_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign db[g] = db_q;
  end

  logic          press_ss_q;
  logic          lap_short_q;
  logic          lap_long_q;
  logic [HW-1:0] hold_lap_q;
  logic          ss_clr;

`ifdef SS_LONG_CLEAR_EN
  logic          ss_long_q;
  logic [HW-1:0] hold_ss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_long_q <= 1'b0;
      hold_ss_q <= '0;
    end else begin
      ss_long_q <= db[0] && (hold_ss_q == LONG_M1);
      if (!db[0])                hold_ss_q <= '0;
      else if (hold_ss_q != LONG_V) hold_ss_q <= hold_ss_q + 1'b1;
    end
  end

  assign ss_clr = ss_long_q;
`else
  assign ss_clr = 1'b0;
`endif

  // Hold counter saturates, so hold == LONG-1 with db high is seen once per hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_dly_q    <= '0;
      press_ss_q  <= 1'b0;
      lap_short_q <= 1'b0;
      lap_long_q  <= 1'b0;
      hold_lap_q  <= '0;
    end else begin
      db_dly_q    <= db;
      press_ss_q  <= db[0] & ~db_dly_q[0];
      lap_short_q <= ~db[1] & db_dly_q[1] & (hold_lap_q != LONG_V);
      lap_long_q  <= db[1] && (hold_lap_q == LONG_M1);
      if (!db[1])                    hold_lap_q <= '0;
      else if (hold_lap_q != LONG_V) hold_lap_q <= hold_lap_q + 1'b1;
    end
  end

  state_e state_q, state_d;
  logic   count_en_q, lap_hold_q, count_clr_q;

  always_comb begin
    state_d = state_q;
    if (ss_clr && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else if (press_ss_q) begin
      state_d = (state_q == ST_RUN || state_q == ST_LAP) ? ST_PAUSE : ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN:   if (lap_short_q) state_d = ST_LAP;
        ST_LAP:   if (lap_short_q) state_d = ST_RUN;
        ST_PAUSE: if (lap_long_q)  state_d = ST_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Outputs are registered from state_d so they always match the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_en_q  <= 1'b0;
      lap_hold_q  <= 1'b0;
      count_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_en_q  <= (state_d == ST_RUN) || (state_d == ST_LAP);
      lap_hold_q  <= (state_d == ST_LAP);
      count_clr_q <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end
  end

  assign pnl.state     = state_q;
  assign pnl.count_en  = count_en_q;
  assign pnl.lap_hold  = lap_hold_q;
  assign pnl.count_clr = count_clr_q;

endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
// Bench for stopwatch_mode_ctrl: directed button scenarios, a cycle model derived from
// the debounce/press/hold rules, and literal expectations at the key points.
module tb_stopwatch_mode_ctrl;
  localparam int DB = 4;
  localparam int LG = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stopwatch_mode_ctrl_if pnl ();

  stopwatch_mode_ctrl #(.DB_CYCLES(DB), .LONG_CYCLES(LG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pnl   (pnl.slave)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int clr_cnt;

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s (cycle %0d): got %0d expected %0d", nm, cyc, got, exp);
  endtask

  // ---------------- model ----------------
  // Raw sample history per button (index 0 = latest edge); a debounced level takes the
  // value of the synchronised input once the last DB synchronised samples all agree.
  bit rh   [2][DB+2];
  bit dbh  [2][2];     // db after previous edge, and the one before
  int run  [2][2];     // consecutive cycles db has been high, same two points in time
  bit ev_press, ev_short, ev_long, ev_sslong;
  bit newdb [2];
  int mstate, mprev;
  bit mclr;

  function automatic int next_state(int s, bit pss, bit shrt, bit llong, bit sslong);
    if (sslong && s != 0) return 0;
    if (pss) return (s == 1 || s == 3) ? 2 : 1;
    case (s)
      1:       return shrt  ? 3 : 1;
      3:       return shrt  ? 1 : 3;
      2:       return llong ? 0 : 2;
      default: return s;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < DB + 2; k++) rh[b][k] = 1'b0;
        dbh[b][0] = 1'b0; dbh[b][1] = 1'b0;
        run[b][0] = 0;    run[b][1] = 0;
      end
      {ev_press, ev_short, ev_long, ev_sslong} = '0;
      mstate = 0; mprev = 0; mclr = 1'b0;
    end else begin
      cyc++;
      for (int b = 0; b < 2; b++) begin
        bit same;
        for (int k = DB + 1; k > 0; k--) rh[b][k] = rh[b][k-1];
        rh[b][0] = (b == 0) ? pnl.btn_ss : pnl.btn_lap;
        same = 1'b1;
        for (int k = 2; k <= DB + 1; k++) if (rh[b][k] != rh[b][2]) same = 1'b0;
        newdb[b] = same ? rh[b][2] : dbh[b][0];
      end
      mprev  = mstate;
      mstate = next_state(mstate, ev_press, ev_short, ev_long, ev_sslong);
      mclr   = (mprev != 0) && (mstate == 0);
      ev_press = dbh[0][0] && !dbh[0][1];
      ev_short = !dbh[1][0] && dbh[1][1] && (run[1][1] < LG);
      ev_long  = (run[1][0] == LG);
`ifdef SS_LONG_CLEAR_EN
      ev_sslong = (run[0][0] == LG);
`else
      ev_sslong = 1'b0;
`endif
      for (int b = 0; b < 2; b++) begin
        dbh[b][1] = dbh[b][0];
        dbh[b][0] = newdb[b];
        run[b][1] = run[b][0];
        run[b][0] = newdb[b] ? run[b][0] + 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("state",     int'(pnl.state),     mstate);
      check("count_en",  int'(pnl.count_en),  int'(mstate == 1 || mstate == 3));
      check("lap_hold",  int'(pnl.lap_hold),  int'(mstate == 3));
      check("count_clr", int'(pnl.count_clr), int'(mclr));
      clr_cnt += int'(pnl.count_clr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_ss();
    pnl.btn_ss = 1'b1; cycles(10);
    pnl.btn_ss = 1'b0; cycles(12);
  endtask

  task automatic lap_hold_for(input int hi);
    pnl.btn_lap = 1'b1; cycles(hi);
    pnl.btn_lap = 1'b0; cycles(15);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    cycles(2);      rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pnl.btn_ss = 1'b0; pnl.btn_lap = 1'b0; clr_cnt = 0;
    cycles(3); rst_n = 1'b1;
    cycles(1);
    check("reset_state", int'(pnl.state), 0);
    check("reset_en",    int'(pnl.count_en), 0);

    // 1: START press latency is DB+3 edges
    pnl.btn_ss = 1'b1;
    cycles(7);
    check("t1_edge6_state", int'(pnl.state), 0);
    cycles(1);
    check("t1_edge7_state", int'(pnl.state), 1);
    check("t1_edge7_en",    int'(pnl.count_en), 1);
    cycles(4); pnl.btn_ss = 1'b0; cycles(20);
    check("t1_after_release", int'(pnl.state), 1);

    // 2: bounce shorter than the debounce window is rejected
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pnl.btn_ss = 1'b1; cycles(3);
      pnl.btn_ss = 1'b0; cycles(3);
    end
    cycles(15);
    check("t2_state", int'(pnl.state), 0);
    check("t2_en",    int'(pnl.count_en), 0);

    // 3: short LAP toggles RUN <-> LAP
    press_ss();
    check("t3_run", int'(pnl.state), 1);
    lap_hold_for(10);
    check("t3_lap_state", int'(pnl.state), 3);
    check("t3_lap_hold",  int'(pnl.lap_hold), 1);
    check("t3_lap_en",    int'(pnl.count_en), 1);
    lap_hold_for(10);
    check("t3_back_state", int'(pnl.state), 1);
    check("t3_back_hold",  int'(pnl.lap_hold), 0);

    // 4: long LAP clears only from PAUSE
    press_ss();
    check("t4_pause", int'(pnl.state), 2);
    clr_cnt = 0;
    lap_hold_for(40);
    check("t4_clr_pulses", clr_cnt, 1);
    check("t4_idle",       int'(pnl.state), 0);
    press_ss();
    clr_cnt = 0;
    lap_hold_for(40);
    check("t4_run_clr_pulses", clr_cnt, 0);
    check("t4_run_state",      int'(pnl.state), 1);

    // 5: ss_press and lap_short in the same cycle -> press wins
    pnl.btn_lap = 1'b1; cycles(10);
    pnl.btn_lap = 1'b0; pnl.btn_ss = 1'b1; cycles(10);
    pnl.btn_ss = 1'b0; cycles(15);
    check("t5_state", int'(pnl.state), 2);
    check("t5_hold",  int'(pnl.lap_hold), 0);

    // 6: async reset from LAP, START held through release
    press_ss();
    lap_hold_for(10);
    check("t6_lap", int'(pnl.state), 3);
    @(negedge clk); pnl.btn_ss = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_state", int'(pnl.state), 0);
    check("t6_rst_en",    int'(pnl.count_en), 0);
    check("t6_rst_hold",  int'(pnl.lap_hold), 0);
    check("t6_rst_clr",   int'(pnl.count_clr), 0);
    cycles(2); rst_n = 1'b1;
    cycles(10);
    check("t6_held_run", int'(pnl.state), 1);
    check("t6_held_en",  int'(pnl.count_en), 1);
    pnl.btn_ss = 1'b0; cycles(15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stopwatch_mode_ctrl.md
Name: stopwatch_mode_ctrl

Overview:
- Front-panel controller for the stopwatch counter datapath.
- Takes two raw push-buttons: START/STOP and LAP.
- Synchronises, debounces and single-pulses each button, and classifies LAP presses as short or long.
- Sequences the counter through IDLE/RUN/LAP/PAUSE via count enable, clear and display-hold controls.

Parameters:
DB_CYCLES, 16, consecutive stable cycles required before a debounced level changes (>=2)
LONG_CYCLES, 1000, LAP hold length (cycles of debounced-high) that counts as a long press (>DB_CYCLES)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
btn_ss  input  1  raw START/STOP button, active-high, asynchronous to clk
btn_lap  input  1  raw LAP button, active-high, asynchronous to clk
count_en  output  1  counter increment enable
count_clr  output  1  one-cycle counter clear pulse
lap_hold  output  1  freeze display at lap value
state  output  2  current state: IDLE=00, RUN=01, PAUSE=10, LAP=11

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; count_en=0, count_clr=0, lap_hold=0.
  - All synchroniser flops, debounced levels, delay flops and counters are 0.
  - Outputs go low immediately on reset assertion, not at the next clock edge.
- Per button, synchroniser:
  - 2-flop synchroniser produces sync level s.
- Per button, debounce:
  - Counter increments each cycle while s != db, and clears when s == db.
  - When s != db and counter == DB_CYCLES-1, db toggles on the next edge and the counter clears.
  - Any mismatch shorter than DB_CYCLES cycles is rejected.
- Per button, press pulse:
  - Registered edge detect: db_dly <= db; press <= db & ~db_dly.
  - Gives exactly one 1-cycle pulse per debounced rising edge.
- LAP classification:
  - hold counter, width ceil(log2(LONG_CYCLES+1)), counts while db_lap=1, saturates at LONG_CYCLES, clears when db_lap=0.
  - lap_long: registered 1-cycle pulse in the cycle after the counter first reaches LONG_CYCLES; once per hold.
  - lap_short: registered 1-cycle pulse on the db_lap falling edge if the counter < LONG_CYCLES.
  - Release after a long press produces no lap_short.
- Latency: a clean raw rising edge first sampled at edge 0 changes state/outputs on edge DB_CYCLES+3.
- FSM (Moore; outputs decoded from state register; evaluated on registered event pulses):
  - IDLE: count_en=0, lap_hold=0. ss_press -> RUN. Lap events ignored.
  - RUN: count_en=1, lap_hold=0. ss_press -> PAUSE. lap_short -> LAP. lap_long ignored.
  - LAP: count_en=1, lap_hold=1. ss_press -> PAUSE. lap_short -> RUN. lap_long ignored.
  - PAUSE: count_en=0, lap_hold=0. ss_press -> RUN. lap_long -> IDLE. lap_short ignored.
- count_clr:
  - Registered; high for exactly the one cycle in which state first reads IDLE after PAUSE->IDLE.
  - Never asserted otherwise.
- Simultaneous events: ss_press has priority. A lap event arriving in the same cycle is dropped, not queued.
- Button held across reset release: db starts at 0, so after debounce a press pulse is generated and acted on.
- Illegal/unreachable states: none; all 4 encodings are legal.

Optional Feature:
SS_LONG_CLEAR_EN
- Defined:
  - btn_ss gets its own hold counter and ss_long pulse, same rules as lap_long, threshold LONG_CYCLES.
  - ss_long in RUN, LAP or PAUSE -> IDLE with count_clr pulse; ignored in IDLE.
  - ss_press still acts on the press edge. Example: from RUN, press -> PAUSE immediately; holding to LONG_CYCLES -> IDLE + clear.
  - ss_long beats a simultaneous lap event.
- Undefined:
  - No ss hold counter; holding btn_ss has no effect beyond the single press.
  - Clear only via lap_long in PAUSE.

Test Plan:
All tests use DB_CYCLES=4, LONG_CYCLES=20.
1. Reset, btn_ss high 12 cycles from edge 0 -> state 00->01 and count_en=1 exactly at edge 7; no further change on release.
2. From IDLE, btn_ss toggled 3 cycles high / 3 low for 30 cycles, then low -> state stays 00, count_en=0 throughout.
3. In RUN, btn_lap high 10 cycles -> state=11, lap_hold=1, count_en=1 after release + debounce; repeat -> state=01, lap_hold=0.
4. In PAUSE, btn_lap held 40 cycles -> single count_clr pulse, state=00; same hold in RUN -> state stays 01, no count_clr.
5. In RUN, raw inputs timed so ss_press and lap_short pulse in the same cycle -> state=10, lap_hold=0, lap event lost.
6. In LAP, rst_n pulled low mid-cycle -> count_en, lap_hold, count_clr=0 and state=00 before the next clock edge; btn_ss held through reset release -> RUN after debounce.
